score_renderer: RTL

- Pixel-colour stage directly downstream of the VGA timing generator in Scoreboard_v2.
- Consumes the pixel position and syncs, draws two 2-digit seven-segment scores (team A, team B), and blinks the winner's score.
- Delays the syncs so they stay aligned with the colour. Its outputs drive the board's VGA pins.

---
 rtl/score_renderer_pkg.sv | 46 ++++
 rtl/score_renderer_if.sv | 11 +
 rtl/score_renderer_bcd.sv | 58 +++++
 rtl/score_renderer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/score_renderer_pkg.sv
// Shared constants for the score renderer: segment maps, winner codes,
// colours and the BCD converter state encodings.
package scb_pkg;

  // Segment maps, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  localparam logic [11:0] RGB_OFF = 12'h000;
  localparam logic [11:0] RGB_FG  = 12'hFFF;
  localparam logic [11:0] RGB_BG  = 12'h008;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SUB_A = 2'd1;
  localparam logic [1:0] ST_SUB_B = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [6:0] seg_map(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Pixel position / sync bus coming from the VGA timing stage.
interface score_renderer_if;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       de_in;
  logic [9:0] x_in;
  logic [9:0] y_in;

  modport master (output h_sync_in, v_sync_in, de_in, x_in, y_in);
  modport slave  (input  h_sync_in, v_sync_in, de_in, x_in, y_in);
endinterface

// File: rtl/score_renderer_bcd.sv
// Iterative subtract-10 binary to BCD converter for both team scores.
// A start in any state restarts from the new inputs; o_done is high for
// one cycle in DONE, when the digit outputs are valid.
module score_bcd
  import scb_pkg::*;
(
  input  logic       clk_scb,
  input  logic       rst_n_scb,
  input  logic       i_start,
  input  logic [6:0] i_val_a,
  input  logic [6:0] i_val_b,
  output logic       o_done,
  output logic [3:0] o_tens_a,
  output logic [3:0] o_ones_a,
  output logic [3:0] o_tens_b,
  output logic [3:0] o_ones_b
);
  logic [1:0] r_state;
  logic [6:0] r_rem_a, r_rem_b;
  logic [3:0] r_cnt_a, r_cnt_b;

  // FSM: peel off one ten per cycle, team A first, then team B
  always_ff @(posedge clk_scb or negedge rst_n_scb) begin
    if (!rst_n_scb) begin
      r_state <= ST_IDLE;
      r_rem_a <= '0;
      r_rem_b <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (i_start) begin
      r_state <= ST_SUB_A;
      r_rem_a <= i_val_a;
      r_rem_b <= i_val_b;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      case (r_state)
        ST_SUB_A:
          if (r_rem_a >= 7'd10) begin
            r_rem_a <= r_rem_a - 7'd10;
            r_cnt_a <= r_cnt_a + 4'd1;
          end else r_state <= ST_SUB_B;
        ST_SUB_B:
          if (r_rem_b >= 7'd10) begin
            r_rem_b <= r_rem_b - 7'd10;
            r_cnt_b <= r_cnt_b + 4'd1;
          end else r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_done   = (r_state == ST_DONE);
  assign o_tens_a = r_cnt_a;
  assign o_tens_b = r_cnt_b;
  assign o_ones_a = 4'(r_rem_a);
  assign o_ones_b = 4'(r_rem_b);
endmodule

// File: rtl/score_renderer.sv
// Score overlay stage: draws two 2-digit seven-segment scores over the
// VGA raster, blinks the winner, and delays the syncs to match colour.
module score_renderer
  import scb_pkg::*;
#(
  parameter int          DIGIT_W      = 32,
  parameter int          DIGIT_H      = 64,
  parameter int          SEG_T        = 6,
  parameter int          DIGIT_GAP    = 8,
  parameter int          ORIGIN_Y     = 64,
  parameter int          A_X          = 160,
  parameter int          B_X          = 416,
  parameter logic [11:0] FG_RGB       = RGB_FG,
  parameter logic [11:0] BG_RGB       = RGB_BG,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic               clk_scb,
  input  logic               rst_n_scb,
  score_renderer_if.slave    pix,
  input  logic [6:0]         score_a_in,
  input  logic [6:0]         score_b_in,
  input  logic [1:0]         winner_in,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [11:0]        rgb_out,
  output logic               frame_tick_out
);
  localparam logic [9:0] C_AT_L  = 10'(A_X);
  localparam logic [9:0] C_AT_R  = 10'(A_X + DIGIT_W - 1);
  localparam logic [9:0] C_AO_L  = 10'(A_X + DIGIT_W + DIGIT_GAP);
  localparam logic [9:0] C_AO_R  = 10'(A_X + 2*DIGIT_W + DIGIT_GAP - 1);
  localparam logic [9:0] C_BT_L  = 10'(B_X);
  localparam logic [9:0] C_BT_R  = 10'(B_X + DIGIT_W - 1);
  localparam logic [9:0] C_BO_L  = 10'(B_X + DIGIT_W + DIGIT_GAP);
  localparam logic [9:0] C_BO_R  = 10'(B_X + 2*DIGIT_W + DIGIT_GAP - 1);
  localparam logic [9:0] C_ROW_T = 10'(ORIGIN_Y);
  localparam logic [9:0] C_ROW_B = 10'(ORIGIN_Y + DIGIT_H - 1);
  localparam logic [9:0] C_SEG_T = 10'(SEG_T);
  localparam logic [9:0] C_D_TOP = 10'(DIGIT_H - SEG_T);
  localparam logic [9:0] C_G_LO  = 10'(DIGIT_H/2 - SEG_T/2);
  localparam logic [9:0] C_G_HI  = 10'(DIGIT_H/2 + SEG_T/2 - 1);
  localparam logic [9:0] C_MID   = 10'(DIGIT_H/2);
  localparam logic [9:0] C_R_COL = 10'(DIGIT_W - SEG_T);
  localparam int         CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // stage 1 / stage 2 pipeline registers
  logic       r1_de, r1_hs, r1_vs, r1_hit;
  logic [1:0] r1_sel;                 // {team B, ones box}
  logic [9:0] r1_lx, r1_ly;
  logic       r2_hs, r2_vs;
  logic [11:0] r_rgb;

  // frame-latched state
  logic             r_tick, r_phase;
  logic [6:0]       r_sa, r_sb;
  logic [1:0]       r_win;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_tens_a, r_ones_a, r_tens_b, r_ones_b;

  logic       w_col_hit, w_row_hit, w_edge, w_done;
  logic [1:0] w_sel;
  logic [9:0] w_lx, w_ly;
  logic [3:0] w_bt_a, w_bo_a, w_bt_b, w_bo_b;
  logic [3:0] w_digit;
  logic [6:0] w_map, w_segs;
  logic       w_upper, w_left, w_right, w_blank, w_lit, w_blink;

  // Column decode: which digit box (if any) the pixel falls in
  always_comb begin
    w_col_hit = 1'b1;
    w_sel     = 2'b00;
    w_lx      = pix.x_in - C_AT_L;
    if (pix.x_in >= C_AT_L && pix.x_in <= C_AT_R) begin
      w_sel = 2'b00; w_lx = pix.x_in - C_AT_L;
    end else if (pix.x_in >= C_AO_L && pix.x_in <= C_AO_R) begin
      w_sel = 2'b01; w_lx = pix.x_in - C_AO_L;
    end else if (pix.x_in >= C_BT_L && pix.x_in <= C_BT_R) begin
      w_sel = 2'b10; w_lx = pix.x_in - C_BT_L;
    end else if (pix.x_in >= C_BO_L && pix.x_in <= C_BO_R) begin
      w_sel = 2'b11; w_lx = pix.x_in - C_BO_L;
    end else begin
      w_col_hit = 1'b0;
    end
  end

  assign w_row_hit = (pix.y_in >= C_ROW_T) && (pix.y_in <= C_ROW_B);
  assign w_ly      = pix.y_in - C_ROW_T;

  // Stage 1: register syncs, enable, box hit and local coordinates
  always_ff @(posedge clk_scb or negedge rst_n_scb) begin
    if (!rst_n_scb) begin
      r1_de <= 1'b0; r1_hs <= 1'b0; r1_vs <= 1'b0; r1_hit <= 1'b0;
      r1_sel <= '0; r1_lx <= '0; r1_ly <= '0;
    end else begin
      r1_de  <= pix.de_in;
      r1_hs  <= pix.h_sync_in;
      r1_vs  <= pix.v_sync_in;
      r1_hit <= w_col_hit && w_row_hit;
      r1_sel <= w_sel;
      r1_lx  <= w_lx;
      r1_ly  <= w_ly;
    end
  end

  // r2_vs is the previous r1_vs, so this is the registered rising edge
  assign w_edge = r1_vs & ~r2_vs;

  // Frame boundary: latch clipped scores and winner, advance blink timer
  always_ff @(posedge clk_scb or negedge rst_n_scb) begin
    if (!rst_n_scb) begin
      r_tick <= 1'b0; r_sa <= '0; r_sb <= '0; r_win <= WIN_NONE;
      r_cnt <= '0; r_phase <= 1'b0;
    end else begin
      r_tick <= w_edge;
      if (w_edge) begin
        r_sa  <= (score_a_in > 7'd99) ? 7'd99 : score_a_in;
        r_sb  <= (score_b_in > 7'd99) ? 7'd99 : score_b_in;
        r_win <= winner_in;
        if (r_cnt == C_CNT_LAST) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  score_bcd u_bcd (
    .clk_scb  (clk_scb),
    .rst_n_scb(rst_n_scb),
    .i_start  (r_tick),
    .i_val_a  (r_sa),
    .i_val_b  (r_sb),
    .o_done   (w_done),
    .o_tens_a (w_bt_a),
    .o_ones_a (w_bo_a),
    .o_tens_b (w_bt_b),
    .o_ones_b (w_bo_b)
  );

  // Displayed digits change all at once when the converter finishes
  always_ff @(posedge clk_scb or negedge rst_n_scb) begin
    if (!rst_n_scb) begin
      r_tens_a <= '0; r_ones_a <= '0; r_tens_b <= '0; r_ones_b <= '0;
    end else if (w_done) begin
      r_tens_a <= w_bt_a; r_ones_a <= w_bo_a;
      r_tens_b <= w_bt_b; r_ones_b <= w_bo_b;
    end
  end

  // Stage 2 decode: segment regions, digit lookup, blanking and blink
  always_comb begin
    case (r1_sel)
      2'b00:   w_digit = r_tens_a;
      2'b01:   w_digit = r_ones_a;
      2'b10:   w_digit = r_tens_b;
      default: w_digit = r_ones_b;
    endcase
    w_map   = seg_map(w_digit);
    w_upper = r1_ly < C_MID;
    w_left  = r1_lx < C_SEG_T;
    w_right = r1_lx >= C_R_COL;
    w_segs  = {r1_ly < C_SEG_T,                      // a
               w_right && w_upper,                   // b
               w_right && !w_upper,                  // c
               r1_ly >= C_D_TOP,                     // d
               w_left && !w_upper,                   // e
               w_left && w_upper,                    // f
               (r1_ly >= C_G_LO) && (r1_ly <= C_G_HI)}; // g
    w_blank = !r1_sel[0] && (w_digit == 4'd0);
    w_lit   = r1_hit && !w_blank && (|(w_map & w_segs));
    w_blink = r_phase && (r1_sel[1] ? (r_win == WIN_B) : (r_win == WIN_A));
  end

  // Stage 2: colour mux and second sync delay
  always_ff @(posedge clk_scb or negedge rst_n_scb) begin
    if (!rst_n_scb) begin
      r2_hs <= 1'b0; r2_vs <= 1'b0; r_rgb <= RGB_OFF;
    end else begin
      r2_hs <= r1_hs;
      r2_vs <= r1_vs;
      if (!r1_de)                 r_rgb <= RGB_OFF;
      else if (w_lit && !w_blink) r_rgb <= FG_RGB;
      else                        r_rgb <= BG_RGB;
    end
  end

  assign h_sync_out     = r2_hs;
  assign v_sync_out     = r2_vs;
  assign rgb_out        = r_rgb;
  assign frame_tick_out = r_tick;
endmodule
